// File: rtl/mem_xfer_ctl_if.sv
// Request/ack handshake, write gate and bit/word timing bus between a
// transfer requester (master) and mem_xfer_ctl (slave).
interface mem_xfer_ctl_if;
    logic       bt;
    logic       req;
    logic [4:0] src;
    logic [4:0] dst;
    logic [6:0] tw;
    logic [6:0] nw;
    logic       abort;
    logic       ack;
    logic       busy;
    logic       done;
    logic       err;
    logic       wg;
    logic [4:0] src_sel;
    logic [4:0] dst_sel;
    logic [4:0] bit_t;
    logic [6:0] word_t;
    logic       t0;

    modport master (
        output bt, req, src, dst, tw, nw, abort,
        input  ack, busy, done, err, wg, src_sel, dst_sel, bit_t, word_t, t0
    );

    modport slave (
        input  bt, req, src, dst, tw, nw, abort,
        output ack, busy, done, err, wg, src_sel, dst_sel, bit_t, word_t, t0
    );
endinterface

// File: rtl/mem_xfer_ctl.sv
// Line-to-line transfer controller: free-running 29-bit x 108-word timing,
// request accept/reject, word alignment and a bit-counted write gate.
module mem_xfer_ctl (
    input  logic          clock,
    input  logic          rst,
    mem_xfer_ctl_if.slave xf
);
    localparam logic [4:0] BIT_LAST  = 5'd28;
    localparam logic [6:0] WORD_LAST = 7'd107;
    localparam logic [6:0] NW_MAX    = 7'd108;

    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_XFER, S_DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic [4:0]  bit_t;
    logic [6:0]  word_t;
    logic [4:0]  src_q;
    logic [4:0]  dst_q;
    logic [6:0]  tw_q;
    logic [12:0] rem_bits;
    logic        ack_q;
    logic        err_q;
    logic        accept;
    logic        reject;
    logic        bad_req;
    logic        short_line;
    logic        word_match;
    logic        align_hit;
    logic        busy;

    assign bad_req    = (xf.nw == 7'd0) || (xf.nw > NW_MAX) || (xf.tw > WORD_LAST);
    assign short_line = (dst_q[4:2] == 3'b101);
    assign word_match = short_line ? (word_t[1:0] == tw_q[1:0]) : (word_t == tw_q);
    // ack_q marks the ACK cycle, whose match instant must be skipped
    assign align_hit  = xf.bt && (bit_t == 5'd0) && word_match && !ack_q;

    always_ff @(posedge clock) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            S_IDLE: begin
                if (xf.req && !xf.abort) begin
                    if (bad_req) begin
                        reject = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        next_state = S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                if (xf.abort) begin
                    next_state = S_IDLE;
                end else if (align_hit) begin
                    next_state = S_XFER;
                end
            end
            S_XFER: begin
                if (xf.abort) begin
                    next_state = S_IDLE;
                end else if (xf.bt && (rem_bits == 13'd1)) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            bit_t    <= 5'd0;
            word_t   <= 7'd0;
            src_q    <= 5'd0;
            dst_q    <= 5'd0;
            tw_q     <= 7'd0;
            rem_bits <= 13'd0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ack_q <= accept;
            err_q <= reject;
            if (xf.bt) begin
                if (bit_t == BIT_LAST) begin
                    bit_t  <= 5'd0;
                    word_t <= (word_t == WORD_LAST) ? 7'd0 : word_t + 7'd1;
                end else begin
                    bit_t <= bit_t + 5'd1;
                end
            end
            if (accept) begin
                src_q    <= xf.src;
                dst_q    <= xf.dst;
                tw_q     <= xf.tw;
                rem_bits <= {6'd0, xf.nw} * 13'd29;
            end else if ((state == S_XFER) && xf.bt) begin
                rem_bits <= rem_bits - 13'd1;
            end
        end
    end

    assign busy       = (state == S_ALIGN) || (state == S_XFER);
    assign xf.busy    = busy;
    assign xf.wg      = (state == S_XFER);
    assign xf.done    = (state == S_DONE);
    assign xf.ack     = ack_q;
    assign xf.err     = err_q;
    assign xf.src_sel = busy ? src_q : 5'd0;
    assign xf.dst_sel = busy ? dst_q : 5'd0;
    assign xf.bit_t   = bit_t;
    assign xf.word_t  = word_t;
    assign xf.t0      = (bit_t == 5'd0);
endmodule

// File: tb/tb_mem_xfer_ctl.sv
// Directed bench for mem_xfer_ctl: timing free-run, long/short/wrapping
// transfers, rejects, abort, throttled strobes and mid-transfer reset.
module tb_mem_xfer_ctl;
    logic clock;
    logic rst;
    int   checks;
    int   errors;
    int   rise_w;
    int   rise_b;
    int   wg_cycles;
    int   strobes;
    int   wrap_seen;
    int   t0_count;
    int   n;
    int   phase;

    mem_xfer_ctl_if xf ();

    mem_xfer_ctl dut (
        .clock (clock),
        .rst   (rst),
        .xf    (xf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic [4:0] s, input logic [4:0] d,
                                  input logic [6:0] t, input logic [6:0] w);
        xf.req = r;
        xf.src = s;
        xf.dst = d;
        xf.tw  = t;
        xf.nw  = w;
    endtask

    task automatic wait_frame(input int w, input int b);
        int k;
        k = 0;
        while (!((int'(xf.word_t) == w) && (int'(xf.bit_t) == b)) && (k < 5000)) begin
            tick();
            k++;
        end
        check_output("wait_frame_reached", 32'(k < 5000), 32'd1);
    endtask

    // Follows one transfer from ALIGN until WG falls; leaves bench in the DONE cycle.
    task automatic watch_transfer(input bit throttle);
        int  k;
        int  ph;
        int  pw;
        int  pb;
        bit  risen;
        k = 0; ph = 0; risen = 1'b0;
        rise_w = -1; rise_b = -1; wg_cycles = 0; strobes = 0; wrap_seen = 0;
        while (k < 12000) begin
            xf.bt = throttle ? (ph == 0) : 1'b1;
            ph = (ph == 2) ? 0 : ph + 1;
            if (xf.wg) begin
                wg_cycles++;
                if (xf.bt) strobes++;
                if (xf.word_t == 7'd0) wrap_seen = 1;
            end
            pw = int'(xf.word_t);
            pb = int'(xf.bit_t);
            tick();
            k++;
            if (xf.wg && !risen) begin
                risen  = 1'b1;
                rise_w = pw;
                rise_b = pb;
            end
            if (risen && !xf.wg) break;
        end
        check_output("watch_in_budget", 32'(k < 12000), 32'd1);
        xf.bt = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        xf.bt = 1'b1;
        xf.abort = 1'b0;
        apply_stimulus(1'b0, 5'd0, 5'd0, 7'd0, 7'd0);
        repeat (3) tick();
        check_output("rst_bit_t", xf.bit_t, 0);
        check_output("rst_word_t", xf.word_t, 0);
        check_output("rst_t0", xf.t0, 1);
        check_output("rst_ack", xf.ack, 0);
        check_output("rst_busy", xf.busy, 0);
        check_output("rst_done", xf.done, 0);
        check_output("rst_err", xf.err, 0);
        check_output("rst_wg", xf.wg, 0);
        check_output("rst_src_sel", xf.src_sel, 0);
        check_output("rst_dst_sel", xf.dst_sel, 0);

        // free run: one full 29 x 108 frame
        rst = 1'b1;
        t0_count = 0;
        for (int k = 1; k <= 3132; k++) begin
            tick();
            if (xf.t0) t0_count++;
            if (k == 28) begin
                check_output("run28_bit", xf.bit_t, 28);
                check_output("run28_word", xf.word_t, 0);
            end
            if (k == 29) begin
                check_output("run29_bit", xf.bit_t, 0);
                check_output("run29_word", xf.word_t, 1);
            end
            if (k == 3131) begin
                check_output("run3131_bit", xf.bit_t, 28);
                check_output("run3131_word", xf.word_t, 107);
            end
        end
        check_output("frame_bit", xf.bit_t, 0);
        check_output("frame_word", xf.word_t, 0);
        check_output("frame_t0_count", t0_count, 108);

        xf.bt = 1'b0;
        repeat (5) tick();
        check_output("hold_bit", xf.bit_t, 0);
        check_output("hold_word", xf.word_t, 0);
        xf.bt = 1'b1;

        // long line transfer
        wait_frame(4, 0);
        apply_stimulus(1'b1, 5'd3, 5'd5, 7'd10, 7'd3);
        tick();
        check_output("long_ack", xf.ack, 1);
        check_output("long_busy", xf.busy, 1);
        check_output("long_err", xf.err, 0);
        check_output("long_src_sel", xf.src_sel, 3);
        check_output("long_dst_sel", xf.dst_sel, 5);
        tick();
        check_output("busy_req_ack", xf.ack, 0);
        check_output("busy_req_err", xf.err, 0);
        check_output("busy_req_busy", xf.busy, 1);
        xf.req = 1'b0;
        watch_transfer(1'b0);
        check_output("long_rise_word", rise_w, 10);
        check_output("long_rise_bit", rise_b, 0);
        check_output("long_wg_cycles", wg_cycles, 87);
        check_output("long_done", xf.done, 1);
        check_output("long_busy_end", xf.busy, 0);
        tick();
        check_output("long_done_once", xf.done, 0);
        check_output("long_src_sel_idle", xf.src_sel, 0);

        // transfer across the 107 -> 0 word wrap
        wait_frame(100, 0);
        apply_stimulus(1'b1, 5'd9, 5'd7, 7'd106, 7'd4);
        tick();
        check_output("wrap_ack", xf.ack, 1);
        xf.req = 1'b0;
        watch_transfer(1'b0);
        check_output("wrap_rise_word", rise_w, 106);
        check_output("wrap_rise_bit", rise_b, 0);
        check_output("wrap_wg_cycles", wg_cycles, 116);
        check_output("wrap_seen_word0", wrap_seen, 1);
        check_output("wrap_done", xf.done, 1);
        tick();

        // short line aligns on WORD_T[1:0]
        wait_frame(40, 5);
        apply_stimulus(1'b1, 5'd1, 5'd21, 7'd2, 7'd1);
        tick();
        check_output("short_ack", xf.ack, 1);
        xf.req = 1'b0;
        watch_transfer(1'b0);
        check_output("short_rise_word", rise_w, 42);
        check_output("short_wg_cycles", wg_cycles, 29);
        check_output("short_done", xf.done, 1);
        tick();

        // match instant coinciding with the ACK cycle is skipped
        wait_frame(44, 28);
        apply_stimulus(1'b1, 5'd2, 5'd22, 7'd1, 7'd1);
        tick();
        check_output("coin_ack", xf.ack, 1);
        check_output("coin_ack_word", xf.word_t, 45);
        xf.req = 1'b0;
        watch_transfer(1'b0);
        check_output("coin_rise_word", rise_w, 49);
        check_output("coin_rise_bit", rise_b, 0);
        tick();

        // rejects
        apply_stimulus(1'b1, 5'd1, 5'd5, 7'd5, 7'd0);
        tick();
        check_output("rej_nw0_err", xf.err, 1);
        check_output("rej_nw0_ack", xf.ack, 0);
        check_output("rej_nw0_busy", xf.busy, 0);
        apply_stimulus(1'b1, 5'd1, 5'd5, 7'd108, 7'd1);
        tick();
        check_output("rej_tw108_err", xf.err, 1);
        check_output("rej_tw108_busy", xf.busy, 0);
        apply_stimulus(1'b1, 5'd1, 5'd5, 7'd5, 7'd109);
        tick();
        check_output("rej_nw109_err", xf.err, 1);
        check_output("rej_nw109_ack", xf.ack, 0);
        check_output("rej_nw109_busy", xf.busy, 0);
        xf.req = 1'b0;
        tick();
        check_output("rej_err_pulse", xf.err, 0);

        // largest legal request, aborted in ALIGN
        apply_stimulus(1'b1, 5'd4, 5'd3, 7'd107, 7'd108);
        tick();
        check_output("max_ack", xf.ack, 1);
        check_output("max_busy", xf.busy, 1);
        xf.req = 1'b0;
        xf.abort = 1'b1;
        tick();
        check_output("align_abort_busy", xf.busy, 0);
        check_output("align_abort_wg", xf.wg, 0);
        xf.abort = 1'b0;
        tick();
        check_output("align_abort_done", xf.done, 0);

        // ABORT wins over REQ in IDLE, then REQ is accepted normally
        apply_stimulus(1'b1, 5'd6, 5'd5, 7'd5, 7'd5);
        xf.abort = 1'b1;
        tick();
        check_output("prio_ack", xf.ack, 0);
        check_output("prio_err", xf.err, 0);
        check_output("prio_busy", xf.busy, 0);
        xf.abort = 1'b0;
        tick();
        check_output("post_prio_ack", xf.ack, 1);
        xf.req = 1'b0;
        n = 0;
        while (!xf.wg && (n < 4000)) begin
            tick();
            n++;
        end
        check_output("abort_xfer_wg_rise", xf.wg, 1);
        repeat (39) tick();
        check_output("abort_xfer_word2_wg", xf.wg, 1);
        xf.abort = 1'b1;
        tick();
        check_output("xfer_abort_wg", xf.wg, 0);
        check_output("xfer_abort_busy", xf.busy, 0);
        check_output("xfer_abort_done", xf.done, 0);
        xf.abort = 1'b0;
        tick();
        check_output("xfer_abort_no_done", xf.done, 0);
        apply_stimulus(1'b1, 5'd8, 5'd5, 7'd20, 7'd1);
        tick();
        check_output("after_abort_ack", xf.ack, 1);
        xf.req = 1'b0;
        watch_transfer(1'b0);
        check_output("after_abort_rise_word", rise_w, 20);
        check_output("after_abort_wg_cycles", wg_cycles, 29);
        check_output("after_abort_done", xf.done, 1);
        tick();

        // throttled strobes, one BT in three clocks
        apply_stimulus(1'b1, 5'd2, 5'd20, 7'd3, 7'd1);
        tick();
        check_output("thr_ack", xf.ack, 1);
        xf.req = 1'b0;
        watch_transfer(1'b1);
        check_output("thr_wg_cycles", wg_cycles, 87);
        check_output("thr_strobes", strobes, 29);
        check_output("thr_done", xf.done, 1);
        tick();

        // reset in the middle of a throttled transfer
        apply_stimulus(1'b1, 5'd11, 5'd20, 7'd0, 7'd2);
        tick();
        check_output("rstx_ack", xf.ack, 1);
        xf.req = 1'b0;
        n = 0;
        phase = 0;
        while (!xf.wg && (n < 2000)) begin
            xf.bt = (phase == 0);
            phase = (phase == 2) ? 0 : phase + 1;
            tick();
            n++;
        end
        check_output("rstx_wg_rise", xf.wg, 1);
        for (int k = 0; k < 10; k++) begin
            xf.bt = (phase == 0);
            phase = (phase == 2) ? 0 : phase + 1;
            tick();
        end
        check_output("rstx_src_sel_busy", xf.src_sel, 11);
        rst = 1'b0;
        tick();
        check_output("rstx_wg", xf.wg, 0);
        check_output("rstx_busy", xf.busy, 0);
        check_output("rstx_done", xf.done, 0);
        check_output("rstx_ack0", xf.ack, 0);
        check_output("rstx_err", xf.err, 0);
        check_output("rstx_bit_t", xf.bit_t, 0);
        check_output("rstx_word_t", xf.word_t, 0);
        check_output("rstx_t0", xf.t0, 1);
        check_output("rstx_src_sel", xf.src_sel, 0);
        check_output("rstx_dst_sel", xf.dst_sel, 0);
        rst = 1'b1;
        xf.bt = 1'b1;
        tick();
        check_output("rstx_no_done", xf.done, 0);
        check_output("rstx_wg_stays", xf.wg, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_xfer_ctl.md
MEM_XFER_CTL -- requirements
Module: mem_xfer_ctl

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-low reset.
REQ-002 CLOCK  in  1  system clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous active-low reset, sampled on the CLOCK rising edge.
REQ-004 BT  in  1  bit-time strobe; counters and transfer progress advance only on cycles with BT=1.
REQ-005 REQ  in  1  transfer request, level-held until ACK.
REQ-006 SRC  in  5  source line number, 0..31.
REQ-007 DST  in  5  destination line number, 0..31; 20..23 are short lines.
REQ-008 TW  in  7  start word time.
REQ-009 NW  in  7  word count.
REQ-010 ABORT  in  1  cancel the active transfer.
REQ-011 ACK  out  1  one-cycle pulse when the request is accepted.
REQ-012 BUSY  out  1  high from ACK through the end of transfer.
REQ-013 DONE  out  1  one-cycle pulse on normal completion.
REQ-014 ERR  out  1  one-cycle pulse when a request is rejected.
REQ-015 WG  out  1  destination write gate.
REQ-016 SRC_SEL, DST_SEL  out  5 each  latched line numbers, valid while BUSY.
REQ-017 BIT_T  out  5  bit time, 0..28.
REQ-018 WORD_T  out  7  word time, 0..107.
REQ-019 T0  out  1  high while BIT_T=0.

Function
REQ-020 BIT_T SHALL increment on each BT, wrapping 28->0.
REQ-021 WORD_T SHALL increment on the BT that wraps BIT_T, wrapping 107->0.
REQ-022 When BT=0, BIT_T and WORD_T SHALL hold, and the FSM SHALL make no transfer progress.
REQ-023 The FSM SHALL have four states: IDLE, ALIGN, XFER, DONE.
REQ-024 IDLE: when REQ=1, the block SHALL pulse ACK, latch SRC/DST/TW/NW, and go to ALIGN the next cycle, or go to REJECT handling (REQ-025).
REQ-025 Reject, within IDLE: if NW=0, or NW>108, or TW>107, the block SHALL pulse ERR instead of ACK, stay in IDLE, and leave BUSY=0.
REQ-026 ALIGN->XFER SHALL occur on the first BT where BIT_T=0 and the word match holds.
  - Long line: WORD_T=TW.
  - Short line (DST 20..23): WORD_T[1:0]=TW[1:0].
REQ-027 A match instant that coincides with the ACK cycle SHALL NOT be taken; the next match is used (long line up to 108 words later, short line up to 4 words later).
REQ-028 XFER: WG SHALL be 1 for exactly NW*29 BT strobes, starting at the aligning BT.
  - A 13-bit remaining-bit counter is loaded with NW*29 and decremented per BT.
REQ-029 WORD_T wrap 107->0 during XFER SHALL NOT end or disturb the transfer.
REQ-030 XFER->DONE SHALL occur on the BT that consumes the last bit; WG SHALL go low the same cycle.
REQ-031 DONE SHALL pulse DONE for one cycle, clear BUSY, and return to IDLE.
REQ-032 A new REQ SHALL be accepted no earlier than the cycle after DONE.
REQ-033 ABORT in ALIGN or XFER SHALL force IDLE next cycle, with WG=0, BUSY=0, and no DONE pulse.
REQ-034 ABORT in IDLE SHALL be ignored; ABORT takes priority over a simultaneous REQ.
REQ-035 REQ while BUSY SHALL be ignored, with no ACK and no ERR.
REQ-036 SRC_SEL and DST_SEL SHALL hold the latched values while BUSY and read 0 otherwise.

Reset
REQ-037 While rst=0 at a clock edge, the block SHALL set BIT_T=0, WORD_T=0, state=IDLE, and ACK=BUSY=DONE=ERR=WG=0.
REQ-038 While rst=0 at a clock edge, SRC_SEL=0, DST_SEL=0, the remaining-bit counter=0, and T0=1.
REQ-039 A reset mid-transfer SHALL drop WG the next cycle, with no DONE pulse.

Verification
REQ-040 Free run, BT=1 every cycle: after 29*108 BT, BIT_T=0, WORD_T=0, and T0 has pulsed 108 times.
REQ-041 Long transfer: REQ with DST=5, TW=10, NW=3 while WORD_T=4 -> ACK; WG rises at WORD_T=10/BIT_T=0; WG stays high 87 BT; DONE pulses once; BUSY falls.
REQ-042 Wrap and short line:
  - DST=7, TW=106, NW=4 -> WG spans WORD_T 106,107,0,1.
  - DST=21, TW=2 requested at WORD_T=40/BIT_T=5 -> WG starts at WORD_T=42.
REQ-043 Rejects: NW=0 -> ERR pulse, no ACK. TW=108 -> ERR pulse. NW=109 -> ERR pulse. In all three cases BUSY stays 0.
REQ-044 ABORT during XFER at word 2 of 5 -> WG=0 next cycle, no DONE; a following REQ is ACKed normally.
REQ-045 Throttled BT (1 in 3 cycles) with NW=1 -> WG high for exactly 29 BT strobes (87 clocks); rst=0 mid-XFER -> all outputs per REQ-037.
